axis_fifo: RTL and testbench

Parametrised AXI-Stream buffer and the next generation of the single-entry register slice. It holds up to DEPTH beats of TDATA_WIDTH bits, sustains one beat per cycle in both directions, and adds a single-cycle flush (invalidate) and an occupancy count. It sits between pipeline stages that must be decoupled by more than one beat, such as a fetch queue ahead of decode that is flushed on redirect.

---
 rtl/axis_fifo_pkg.sv | 16 +
 rtl/axis_if.sv | 14 +
 rtl/axis_fifo.sv | 97 +++++++++
 tb/tb_axis_fifo.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/axis_fifo_pkg.sv
// Purpose    : shared defaults and elaboration helpers for the axis_fifo stream buffer.
// Latency    : n/a (package only).
// Backpressure: n/a (package only).
package axis_fifo_pkg;

    // Defaults used by the buffer and its stream interface.
    localparam int AXIS_DEF_TDATA_WIDTH = 32;
    localparam int AXIS_DEF_DEPTH       = 4;

    // The circular buffer relies on pointers wrapping naturally, so DEPTH
    // must be a power of two; a single entry would just be a register slice.
    function automatic bit depth_is_legal(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage : axis_fifo_pkg

// File: rtl/axis_if.sv
// Purpose    : minimal AXI-Stream bundle (tvalid / tdata / tready).
// Latency    : n/a (wires only).
// Backpressure: tready driven by the sink, honoured by the source.
// Ports      : master drives tvalid/tdata and samples tready; slave is the mirror.
interface axis_if #(
    parameter int TDATA_WIDTH = axis_fifo_pkg::AXIS_DEF_TDATA_WIDTH
);
    logic                   tvalid;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tready;

    modport master (output tvalid, output tdata, input  tready);
    modport slave  (input  tvalid, input  tdata, output tready);
endinterface : axis_if

// File: rtl/axis_fifo.sv
// Purpose    : DEPTH-entry AXI-Stream FIFO with single-cycle flush and occupancy count.
// Latency    : 1 cycle from upstream accept to downstream valid; no bypass path.
// Backpressure: sif.tready = not full, from registered count only (no mif.tready path).
// Ports      : clk, rst (async, active-high), sif (upstream slave), mif (downstream
//              master), invalidate (flush, drops stored and same-cycle beats),
//              count (stored beats, 0..DEPTH).
module axis_fifo
    import axis_fifo_pkg::*;
#(
    parameter  int TDATA_WIDTH = AXIS_DEF_TDATA_WIDTH,
    parameter  int DEPTH       = AXIS_DEF_DEPTH,
    localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_if.slave                sif,
    axis_if.master               mif,
    input  logic                 invalidate,
    output logic [CNT_WIDTH-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end

    localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]   count_q,  count_d;
    logic [TDATA_WIDTH-1:0] mem_q [DEPTH];

    logic push;
    logic pop;
    logic out_vld;

    // Ready comes from the registered count alone, so a full buffer cannot
    // accept in the same cycle it pops; this keeps the upstream ready timing
    // independent of the downstream sink.
    assign sif.tready = (count_q != FULL_CNT);

    // A flush hides the head beat in the same cycle so nothing can pop.
    assign out_vld    = (count_q != '0) && !invalidate;
    assign mif.tvalid = out_vld;
    assign mif.tdata  = mem_q[rd_ptr_q];
    assign count      = count_q;

    assign push = sif.tvalid && sif.tready;
    assign pop  = out_vld && mif.tready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (invalidate) begin
            // Any beat accepted this cycle is dropped: wr_ptr stays put and
            // the read side jumps onto it, leaving the buffer empty.
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_WIDTH'(1);
                2'b01:   count_d = count_q - CNT_WIDTH'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately not reset; only pointers and count
    // define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push && !invalidate) begin
            mem_q[wr_ptr_q] <= sif.tdata;
        end
    end

endmodule : axis_fifo

// File: tb/tb_axis_fifo.sv
module tb_axis_fifo;

    localparam int W     = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             invalidate;
    logic [CNT_W-1:0] count;

    axis_if #(.TDATA_WIDTH(W)) s_if ();
    axis_if #(.TDATA_WIDTH(W)) m_if ();

    axis_fifo #(.TDATA_WIDTH(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .sif        (s_if),
        .mif        (m_if),
        .invalidate (invalidate),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the buffer contents as an ordered list of beats.
    logic [W-1:0] model_q [$];
    logic         last_push;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic inv);
        logic exp_full;
        logic exp_vld;
        exp_full = (model_q.size() == DEPTH);
        exp_vld  = (model_q.size() != 0) && !inv;
        chk("sif_tready", W'(s_if.tready), W'(!exp_full));
        chk("mif_tvalid", W'(m_if.tvalid), W'(exp_vld));
        chk("count",      W'(count),       W'(model_q.size()));
        if (exp_vld && m_if.tvalid === 1'b1) begin
            chk("mif_tdata", m_if.tdata, model_q[0]);
        end
    endtask

    // One clock cycle: apply inputs, check combinational outputs against the
    // model, advance the model by the stream rules, then step past the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r, input logic inv);
        logic do_push;
        logic do_pop;
        s_if.tvalid = v;
        s_if.tdata  = d;
        m_if.tready = r;
        invalidate  = inv;
        #1;
        check_outputs(inv);
        do_push = v && (model_q.size() != DEPTH);
        do_pop  = (model_q.size() != 0) && !inv && r;
        last_push = do_push;
        if (inv) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && model_q.size() != 0; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        if (model_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL drain_timeout: observed %0d beats left expected 0", model_q.size());
        end
    endtask

    initial begin
        rst         = 1'b1;
        invalidate  = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b0;

        // Reset state while rst is held.
        #12;
        chk("rst_count",  W'(count),       W'(0));
        chk("rst_tready", W'(s_if.tready), W'(1));
        chk("rst_tvalid", W'(m_if.tvalid), W'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single beat: visible the cycle after the push, gone after the pop.
        cycle(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        chk("single_vld",  W'(m_if.tvalid), W'(1));
        chk("single_data", m_if.tdata,      32'hA5A5_0001);
        chk("single_cnt",  W'(count),       W'(1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);

        // Fill to full, beat 5 held upstream, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
        chk("full_cnt",    W'(count),       W'(DEPTH));
        chk("full_tready", W'(s_if.tready), W'(0));
        cycle(1'b1, W'(5), 1'b0, 1'b0);
        cycle(1'b1, W'(5), 1'b0, 1'b0);
        begin
            logic acc5;
            acc5 = 1'b0;
            for (int k = 0; k < 8 && !acc5; k++) begin
                cycle(1'b1, W'(5), 1'b1, 1'b0);
                acc5 = last_push;
            end
            if (!acc5) begin
                n_cmp++;
                n_fail++;
                $error("FAIL beat5_accept: observed 0 expected 1");
            end
        end
        drain(DEPTH + 4);

        // Streaming through several pointer wraps: occupancy sits at one.
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, W'(i), 1'b1, 1'b0);
            chk("stream_cnt", W'(count), W'(1));
        end
        drain(4);

        // Flush while pushing: 0x10 must never come out; 0x11 is first.
        for (int i = 7; i <= 9; i++) cycle(1'b1, W'(i), 1'b0, 1'b0);
        cycle(1'b1, 32'h10, 1'b1, 1'b1);
        chk("inv_cnt", W'(count), W'(0));
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        chk("inv_next", m_if.tdata, 32'h11);
        drain(4);

        // Held flush drains upstream beats every cycle.
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'h20 + i), 1'b1, 1'b1);
        chk("inv_hold_cnt", W'(count), W'(0));

        // Asynchronous reset between edges with two beats stored.
        cycle(1'b1, 32'h31, 1'b0, 1'b0);
        cycle(1'b1, 32'h32, 1'b0, 1'b0);
        s_if.tvalid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_q.delete();
        chk("arst_tvalid", W'(m_if.tvalid), W'(0));
        chk("arst_count",  W'(count),       W'(0));
        chk("arst_tready", W'(s_if.tready), W'(1));
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Random traffic with occasional flush.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), W'($urandom()), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 31) == 0));
            n_cmp++;
            assert (count <= CNT_W'(DEPTH))
            else begin
                n_fail++;
                $error("FAIL count_bound: observed %0d expected <= %0d", count, DEPTH);
            end
        end
        drain(DEPTH + 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_axis_fifo
